// File: rtl/mux_display_controller.sv
// mux_display_controller: time-multiplexed 7-segment scanner with double-buffered loads, PWM brightness, blink and leading-zero blanking
// Ports: clk/reset_n (async active-low); digits_in + load -> load_ack (pulse when new digits go live);
//        brightness, blink_mask, lz_blank_en (live controls); enable_sel (active-low, digit i on bit NUM_DIGITS-1-i);
//        seg (active-low {g,f,e,d,c,b,a}); frame_start (pulse per scan frame)
module mux_display_controller #(
  parameter int NUM_DIGITS   = 5,
  parameter int REFRESH_DIV  = 8192,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   enable_sel,
  output logic [6:0]              seg,
  output logic                    frame_start
);
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BL_W  = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PS_W-1:0]         prescale_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BL_W-1:0]         blink_cnt_q;
  logic                    blink_phase_q, pending_q, load_ack_q, frame_start_q;
  logic [4*NUM_DIGITS-1:0] display_q, staging_q;
  logic [NUM_DIGITS-1:0]   enable_sel_q, enable_sel_d, lz_mask;
  logic [6:0]              seg_q, seg_d, hex_seg;
  logic                    boundary, lit, zero_run;
  logic [3:0]              cur;
  assign boundary    = idx_q == '0 && prescale_q == '0;
  assign cur         = display_q[{idx_q, 2'b00} +: 4];
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;
  assign enable_sel  = enable_sel_q;
  assign seg         = seg_q;
  // lz_mask[d]: digits 0..d are all zero; the last digit is never included
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int d = 0; d < NUM_DIGITS - 1; d++) begin
      zero_run   = zero_run && display_q[4*d +: 4] == 4'h0;
      lz_mask[d] = zero_run;
    end
  end
  // prescale 0 is the anti-ghosting guard; the top BRIGHT_W bits of prescale set the PWM window
  always_comb begin
    lit = prescale_q != '0 && prescale_q[PS_W-1 -: BRIGHT_W] <= brightness &&
          !(blink_mask[idx_q] && !blink_phase_q) && !(lz_blank_en && lz_mask[idx_q]);
    enable_sel_d = '1;
    enable_sel_d[NUM_DIGITS-1-int'(idx_q)] = !lit;
    seg_d = lit ? hex_seg : 7'h7F;
  end
  always_comb begin
    case (cur)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pending_q     <= 1'b0;
      display_q     <= '0;
      staging_q     <= '0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      enable_sel_q  <= '1;
      seg_q         <= 7'h7F;
    end else begin
      prescale_q <= prescale_q + 1'b1;
      if (prescale_q == '1)
        idx_q <= idx_q == IDX_W'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      if (boundary) begin
        blink_cnt_q <= blink_cnt_q == BL_W'(BLINK_FRAMES - 1) ? '0 : blink_cnt_q + 1'b1;
        if (blink_cnt_q == BL_W'(BLINK_FRAMES - 1))
          blink_phase_q <= !blink_phase_q;
      end
      if (load)
        staging_q <= digits_in;
      // a load on the boundary cycle keeps pending set for the next frame
      pending_q <= load || (pending_q && !boundary);
      if (boundary && pending_q)
        display_q <= staging_q;
      load_ack_q    <= boundary && pending_q;
      frame_start_q <= boundary;
      enable_sel_q  <= enable_sel_d;
      seg_q         <= seg_d;
    end
  end
endmodule

// File: tb/tb_mux_display_controller.sv
// tb_mux_display_controller: directed self-checking bench for mux_display_controller (5 digits, 16-cycle slots)
module tb_mux_display_controller;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19,
                         S5 = 7'h12, S7 = 7'h78, SA = 7'h08, OFF = 7'h7F;
  localparam logic [34:0] SEG12345 = {S5, S4, S3, S2, S1};
  localparam logic [19:0] D12345   = 20'h54321;
  logic        clk = 1'b0, reset_n = 1'b0, load = 1'b0, lz_blank_en = 1'b0;
  logic [19:0] digits_in = '0;
  logic [1:0]  brightness = 2'd3;
  logic [4:0]  blink_mask = '0, enable_sel;
  logic [6:0]  seg;
  logic        load_ack, frame_start;
  int          checks = 0, failures = 0, k = 0, ack_cnt = 0, a_seen = 0;
  always #5 clk = ~clk;
  mux_display_controller #(.NUM_DIGITS(5), .REFRESH_DIV(16), .BRIGHT_W(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .load(load), .load_ack(load_ack),
    .brightness(brightness), .blink_mask(blink_mask), .lz_blank_en(lz_blank_en),
    .enable_sel(enable_sel), .seg(seg), .frame_start(frame_start)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    k++;
    if (load_ack) ack_cnt++;
    if (seg == SA) a_seen++;
  endtask
  task automatic do_load(input logic [19:0] d);
    digits_in = d;
    load = 1'b1;
    step();
  endtask
  task automatic wait_boundary();
    while (k % 80 != 0) step();
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " en"}, enable_sel, 5'h1F);
    check({tag, " seg"}, seg, OFF);
    check({tag, " fs"}, frame_start, 0);
    check({tag, " ack"}, load_ack, 0);
  endtask
  // one full frame: sample j carries counter state j (prescale j%16, digit j/16)
  task automatic check_frame(input logic [4:0] vis, input logic [34:0] segs, input logic [1:0] b, input logic ack);
    int ps, idx;
    logic lit;
    logic [4:0] en;
    for (int j = 0; j < 80; j++) begin
      step();
      ps  = j % 16;
      idx = j / 16;
      lit = ps != 0 && (ps >> 2) <= int'(b) && vis[idx];
      en  = 5'h1F;
      if (lit) en[4-idx] = 1'b0;
      check($sformatf("en k=%0d", k), enable_sel, en);
      check($sformatf("seg k=%0d", k), seg, lit ? segs[7*idx +: 7] : OFF);
      check($sformatf("fs k=%0d", k), frame_start, j == 0);
      if (j == 0) check($sformatf("ack k=%0d", k), load_ack, ack);
    end
  endtask
  initial begin
    int fr;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n   = 1'b1;
    digits_in = D12345;
    load      = 1'b1;
    check_frame(5'h1F, {5{S0}}, 2'd3, 1'b0);
    check_frame(5'h1F, SEG12345, 2'd3, 1'b1);
    ack_cnt = 0;
    a_seen  = 0;
    repeat (5) step();
    do_load({4'hA, 16'h0});
    repeat (2) step();
    do_load({4'h7, 16'h0});
    wait_boundary();
    check_frame(5'h1F, {S7, S0, S0, S0, S0}, 2'd3, 1'b1);
    check("ack_count", ack_cnt, 1);
    check("a_seen", a_seen, 0);
    lz_blank_en = 1'b1;
    step();
    do_load({4'h7, 4'h0, 4'h2, 4'h0, 4'h0});
    wait_boundary();
    check_frame(5'b11100, {S7, S0, S2, OFF, OFF}, 2'd3, 1'b1);
    step();
    do_load(20'h0);
    wait_boundary();
    check_frame(5'b10000, {S0, OFF, OFF, OFF, OFF}, 2'd3, 1'b1);
    lz_blank_en = 1'b0;
    brightness  = 2'd0;
    step();
    do_load(D12345);
    wait_boundary();
    check_frame(5'h1F, SEG12345, 2'd0, 1'b1);
    brightness = 2'd3;
    blink_mask = 5'b00001;
    ack_cnt    = 0;
    step();
    wait_boundary();
    for (int f = 0; f < 4; f++) begin
      fr = k / 80;
      check_frame({4'hF, ((fr + 1) / 2) % 2 == 0}, SEG12345, 2'd3, 1'b0);
    end
    check("blink_no_ack", ack_cnt, 0);
    blink_mask  = '0;
    lz_blank_en = 1'b1;
    repeat (20) step();
    do_load({4'h9, 16'h0});
    check("pre_reset en", enable_sel, 5'b10111);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async");
    repeat (2) @(negedge clk);
    check_reset_vals("held");
    reset_n = 1'b1;
    k       = 0;
    ack_cnt = 0;
    check_frame(5'b10000, {S0, OFF, OFF, OFF, OFF}, 2'd3, 1'b0);
    check_frame(5'b10000, {S0, OFF, OFF, OFF, OFF}, 2'd3, 1'b0);
    check("post_reset_ack", ack_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
